// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer wrapped around a 1-bit ALU.
// Operands are captured on an accepted start and fed to the ALU one bit
// pair per clock, LSB first. The returned result bits are shifted into a
// WIDTH-bit word that is published on the final shift edge.
module alu_bit_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_op,
  input  logic             alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] r_sh_r;
  logic [WIDTH-1:0] result_r;
  logic [1:0]       op_q_r;
  logic [CW-1:0]    cnt_r;
  logic             last_bit_s;

  // The final shift edge is the one on which the counter already sits at WIDTH-1.
  assign last_bit_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start is honoured only in IDLE; DONE always lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting, bit counting and result publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      r_sh_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      op_q_r   <= 2'b00;
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r <= a_in;
            b_sh_r <= b_in;
            op_q_r <= op;
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_SHIFT: begin
          r_sh_r <= {alu_result, r_sh_r[WIDTH-1:1]};
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          if (last_bit_s) begin
            // Counter parks at WIDTH-1; it is cleared on the next capture.
            result_r <= {alu_result, r_sh_r[WIDTH-1:1]};
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: ALU inputs are live only while shifting, all from registers.
  always_comb begin
    alu_a  = 1'b0;
    alu_b  = 1'b0;
    alu_op = 2'b00;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_SHIFT: begin
        alu_a  = a_sh_r[0];
        alu_b  = b_sh_r[0];
        alu_op = op_q_r;
        busy   = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign result = result_r;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed bench for alu_bit_serial_seq: an 8-bit instance for timing and
// functional scenarios and a 2-bit instance swept exhaustively. Each
// instance is closed around a behavioural 1-bit ALU.
module tb_alu_bit_serial_seq;

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic [1:0] op, op2;
  logic [7:0] a_in, b_in;
  logic [1:0] a_in2, b_in2;
  logic       alu_a, alu_b, alu_result;
  logic       alu_a2, alu_b2, alu_result2;
  logic [1:0] alu_op, alu_op2;
  logic       busy, done, busy2, done2;
  logic [7:0] result;
  logic [1:0] result2;

  int checks;
  int errs;

  function automatic logic alu_ref(input logic a, input logic b, input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      2'b11:   return ~(a & b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] word_ref(input logic [1:0] a, input logic [1:0] b, input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      2'b11:   return ~(a & b);
      default: return 2'b00;
    endcase
  endfunction

  assign alu_result  = alu_ref(alu_a, alu_b, alu_op);
  assign alu_result2 = alu_ref(alu_a2, alu_b2, alu_op2);

  alu_bit_serial_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .result(result)
  );

  alu_bit_serial_seq #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .a_in(a_in2), .b_in(b_in2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_result(alu_result2),
    .busy(busy2), .done(done2), .result(result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    op = 2'b00; op2 = 2'b00; a_in = 8'h00; b_in = 8'h00; a_in2 = 2'b00; b_in2 = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op, busy, done, result} !== 13'd0) begin
      errs++; $display("FAIL reset_outputs: got %b expected %b", {alu_a, alu_b, alu_op, busy, done, result}, 13'd0);
    end
    checks++;
    if ({alu_a2, alu_b2, alu_op2, busy2, done2, result2} !== 7'd0) begin
      errs++; $display("FAIL reset_outputs_w2: got %b expected %b", {alu_a2, alu_b2, alu_op2, busy2, done2, result2}, 7'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_and_timing();
    logic [7:0] av, bv;
    int busy_cnt;
    av = 8'hA5; bv = 8'h3C; busy_cnt = 0;
    a_in = av; b_in = bv; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (i < 8) begin
        checks++;
        if ({alu_a, alu_b} !== {av[i], bv[i]}) begin
          errs++; $display("FAIL and_bits[%0d]: got %b expected %b", i, {alu_a, alu_b}, {av[i], bv[i]});
        end
        checks++;
        if (done !== 1'b0 || result !== 8'h00) begin
          errs++; $display("FAIL and_hold[%0d]: got done=%b result=%h expected done=0 result=00", i, done, result);
        end
      end else if (i == 8) begin
        checks++;
        if (done !== 1'b1 || result !== 8'h24) begin
          errs++; $display("FAIL and_done: got done=%b result=%h expected done=1 result=24", done, result);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h24) begin
          errs++; $display("FAIL and_idle: got done=%b busy=%b result=%h expected 0 0 24", done, busy, result);
        end
      end
    end
    checks++;
    if (busy_cnt !== 9) begin
      errs++; $display("FAIL and_busy_cycles: got %0d expected 9", busy_cnt);
    end
  endtask

  task automatic test_or_xor_nand();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [1:0] to [3];
    logic [7:0] te [3];
    logic [7:0] prev;
    ta[0] = 8'hA5; tb[0] = 8'h3C; to[0] = 2'b01; te[0] = 8'hBD;
    ta[1] = 8'hA5; tb[1] = 8'h3C; to[1] = 2'b10; te[1] = 8'h99;
    ta[2] = 8'hFF; tb[2] = 8'h0F; to[2] = 2'b11; te[2] = 8'hF0;
    prev = 8'h24;
    for (int t = 0; t < 3; t++) begin
      a_in = ta[t]; b_in = tb[t]; op = to[t]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clk);
        if (i == 1) begin
          checks++;
          if (alu_op !== to[t]) begin
            errs++; $display("FAIL op%0d_aluop: got %b expected %b", t, alu_op, to[t]);
          end
        end
        if (i < 8) begin
          checks++;
          if (result !== prev || done !== 1'b0) begin
            errs++; $display("FAIL op%0d_hold[%0d]: got result=%h done=%b expected %h 0", t, i, result, done, prev);
          end
        end else if (i == 8) begin
          checks++;
          if (result !== te[t] || done !== 1'b1) begin
            errs++; $display("FAIL op%0d_result: got result=%h done=%b expected %h 1", t, result, done, te[t]);
          end
        end else begin
          checks++;
          if (result !== te[t] || busy !== 1'b0) begin
            errs++; $display("FAIL op%0d_idle: got result=%h busy=%b expected %h 0", t, result, busy, te[t]);
          end
        end
      end
      prev = te[t];
    end
  endtask

  task automatic test_back_to_back();
    a_in = 8'hA5; b_in = 8'h3C; op = 2'b10; start = 1'b1;
    @(negedge clk);
    a_in = 8'h00; b_in = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (done !== ((i == 8) || (i == 18))) begin
        errs++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, done, ((i == 8) || (i == 18)));
      end
      if (i == 9 || i == 19) begin
        checks++;
        if (busy !== 1'b0) begin
          errs++; $display("FAIL b2b_idle[%0d]: got busy=%b expected 0", i, busy);
        end
      end
      if (i == 8) begin
        checks++;
        if (result !== 8'h99) begin
          errs++; $display("FAIL b2b_first: got %h expected 99", result);
        end
      end
      if (i == 18) begin
        checks++;
        if (result !== 8'hFF) begin
          errs++; $display("FAIL b2b_second: got %h expected ff", result);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    done_seen = 0;
    a_in = 8'hA5; b_in = 8'h3C; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({result, busy, done, alu_op} !== 12'd0) begin
      errs++; $display("FAIL midrst_clear: got %b expected %b", {result, busy, done, alu_op}, 12'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0 || result !== 8'h00) begin
      errs++; $display("FAIL midrst_nodone: got pulses=%0d result=%h expected 0 00", done_seen, result);
    end
    a_in = 8'hF0; b_in = 8'hFF; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) begin
        checks++;
        if (result !== 8'hF0 || done !== 1'b1) begin
          errs++; $display("FAIL midrst_next: got result=%h done=%b expected f0 1", result, done);
        end
      end
    end
  endtask

  task automatic test_exhaustive_w2();
    logic [1:0] av, bv, ov, ev;
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          av = 2'(a); bv = 2'(b); ov = 2'(o);
          ev = word_ref(av, bv, ov);
          a_in2 = av; b_in2 = bv; op2 = ov; start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          @(negedge clk);
          @(negedge clk);
          checks++;
          if (result2 !== ev || done2 !== 1'b1) begin
            errs++; $display("FAIL w2_op%0d_a%0d_b%0d: got result=%b done=%b expected %b 1", o, a, b, result2, done2, ev);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errs = 0;
    test_reset();
    test_and_timing();
    test_or_xor_nand();
    test_back_to_back();
    test_reset_mid_op();
    test_exhaustive_w2();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/alu_bit_serial_seq.md
Name: alu_bit_serial_seq

Overview:
- Upstream/downstream sequencer for the 1-bit ALU.
- Accepts WIDTH-bit operands plus a 2-bit opcode. Feeds the ALU one bit pair per clock, LSB first, and reassembles the returned result bits into a WIDTH-bit word.
- Sits between the register file/operand bus and the ALU_1_bit instance, turning the single-bit ALU into a multi-cycle WIDTH-bit unit.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op  input  2  opcode, forwarded unchanged to the ALU.
- a_in  input  WIDTH  operand A, captured on accepted start.
- b_in  input  WIDTH  operand B, captured on accepted start.
- alu_a  output  1  current A bit to the ALU.
- alu_b  output  1  current B bit to the ALU.
- alu_op  output  2  opcode to the ALU.
- alu_result  input  1  combinational result bit from the ALU.
- busy  output  1  high while an operation is in progress (state != IDLE).
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH  last completed result.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; operand shift regs, result shift reg, bit counter, alu_op and result = 0; busy=0; done=0.
- FSM states:
  - IDLE: if start=1 at a rising edge, capture a_in/b_in into shift regs A_sh/B_sh and op into op_q, clear counter, go to SHIFT. Otherwise stay.
  - SHIFT: each edge:
    - R_sh <= {alu_result, R_sh[WIDTH-1:1]}.
    - A_sh, B_sh shift right by 1.
    - counter += 1.
    - When counter reaches WIDTH-1 at that edge (i.e. the WIDTH-th bit is captured), load result <= {alu_result, R_sh[WIDTH-1:1]} and go to DONE.
  - DONE: done=1 for this cycle only; unconditionally return to IDLE.
- ALU outputs:
  - alu_a = A_sh[0] and alu_b = B_sh[0] (registered sources, no combinational path from a_in/b_in).
  - alu_op = op_q during SHIFT, 0 otherwise; alu_a/alu_b also 0 outside SHIFT.
- Latency: start accepted at edge k gives SHIFT for edges k+1..k+WIDTH, done high in the cycle after edge k+WIDTH, and result valid from edge k+WIDTH. Total WIDTH+2 cycles from start to IDLE.
- Holding result: result holds its previous value throughout an operation; it changes only on the final SHIFT edge.
- start while busy (SHIFT or DONE): ignored; no operand recapture. Back-to-back operations need start asserted in IDLE, so the minimum issue interval is WIDTH+2 cycles.
- Operand changes after capture: a_in/b_in/op changes have no effect on the operation in flight.
- Reset mid-operation: immediate return to IDLE, result cleared to 0, no done pulse.
- Counter width: $clog2(WIDTH) bits, with no wrap beyond WIDTH-1.
- Bench ALU model (ALU_1_bit encoding): 00 AND, 01 OR, 10 XOR, 11 NAND.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; busy=0, done=0.
- AND timing: WIDTH=8, op=00, a=0xA5, b=0x3C, start 1 cycle -> busy high 9 cycles; done pulses exactly 1 cycle, 9 cycles after the start edge; result=0x24; alu_a sequence LSB-first 1,0,1,0,0,1,0,1.
- OR/XOR/NAND: op=01, a=0xA5, b=0x3C -> result 0xBD; op=10 -> 0x99; op=11, a=0xFF, b=0x0F -> 0xF0; result stable between done pulses.
- Start while busy: start held high continuously with new operands 0x00/0xFF -> second op begins only after IDLE is revisited; first result unaffected; done pulses every 10 cycles.
- Reset mid-operation: rst asserted at bit 4 of an XOR 0xA5^0x3C -> result=0, no done pulse; next op=00, a=0xF0, b=0xFF -> 0xF0.
- Exhaustive: WIDTH=2, all 4 opcodes x 16 operand pairs -> result matches the bitwise reference model each time.
